// File: rtl/credit_stream_tx.sv
// credit_stream_tx: transmit side of a credit-based flit link.
// Upstream ready/valid stream -> 2-entry spill buffer -> registered flit port.
// A flit is launched only while the registered credit count is non-zero.
// Optional feature macro: CREDIT_STREAM_TX_STATS_EN enables the saturating
// stall-cycle counter on stall_cnt_o; otherwise stall_cnt_o is tied to zero.
module credit_stream_tx #(
  parameter type         T          = logic,
  parameter int unsigned NumCredits = 4,
  parameter int unsigned CntWidth   = $clog2(NumCredits + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                src_valid_i,
  output logic                src_ready_o,
  input  T                    src_data_i,
  output logic                tx_valid_o,
  output T                    tx_data_o,
  input  logic                credit_i,
  output logic [CntWidth-1:0] credits_o,
  output logic                idle_o,
  output logic                credit_err_o,
  output logic [31:0]         stall_cnt_o
);

  localparam logic [CntWidth-1:0] FullCredits = CntWidth'(NumCredits);

  T                    mem [2];
  logic                wr_ptr;
  logic                rd_ptr;
  logic [1:0]          count;
  logic [CntWidth-1:0] credits_q;
  logic                err_q;
  logic                tx_valid_q;
  T                    tx_data_q;

  logic push;
  logic send;
  logic empty;
  logic full;

  // Handshake and launch decisions, all from registered state only
  always_comb begin
    empty = (count == 2'd0);
    full  = (count == 2'd2);
    push  = src_valid_i && !full;
    send  = !empty && (credits_q != '0);
  end

  // Spill buffer storage; contents are don't-care while the slot is empty
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= src_data_i;
    end
  end

  // Buffer pointers and occupancy
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (send) rd_ptr <= ~rd_ptr;
      case ({push, send})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Credit counter with overflow detection; a simultaneous send and return cancel
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      credits_q <= FullCredits;
      err_q     <= 1'b0;
    end else begin
      if (send && !credit_i) begin
        credits_q <= credits_q - CntWidth'(1);
      end else if (!send && credit_i) begin
        if (credits_q == FullCredits) begin
          err_q <= 1'b1;
        end else begin
          credits_q <= credits_q + CntWidth'(1);
        end
      end
    end
  end

  // Registered link output; data holds its last value between pulses
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      tx_valid_q <= send;
      if (send) begin
        tx_data_q <= mem[rd_ptr];
      end
    end
  end

`ifdef CREDIT_STREAM_TX_STATS_EN
  logic [31:0] stall_q;

  // Count cycles where a flit waits only for credit; saturates at all-ones
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_q <= '0;
    end else if (!empty && (credits_q == '0) && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = '0;
`endif

  assign src_ready_o  = !full;
  assign tx_valid_o   = tx_valid_q;
  assign tx_data_o    = tx_data_q;
  assign credits_o    = credits_q;
  assign credit_err_o = err_q;
  assign idle_o       = empty && (credits_q == FullCredits) && !tx_valid_q;

endmodule

// File: tb/tb_credit_stream_tx.sv
// Directed bench for credit_stream_tx (NumCredits=4 main instance, NumCredits=1
// second instance) plus a randomized ordering run against a reference queue.
module tb_credit_stream_tx;

`ifdef CREDIT_STREAM_TX_STATS_EN
  localparam bit Stats = 1'b1;
`else
  localparam bit Stats = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        v0 = 1'b0, rdy0, tx0, c0 = 1'b0, idle0, err0;
  logic [7:0]  d0 = '0, txd0;
  logic [2:0]  cr0;
  logic [31:0] stall0;

  logic        v1 = 1'b0, rdy1, tx1, c1 = 1'b0, idle1, err1;
  logic [7:0]  d1 = '0, txd1;
  logic [0:0]  cr1;
  logic [31:0] stall1;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  credit_stream_tx #(.T(logic [7:0]), .NumCredits(4)) u0 (
    .clk_i(clk), .rst_i(rst), .src_valid_i(v0), .src_ready_o(rdy0),
    .src_data_i(d0), .tx_valid_o(tx0), .tx_data_o(txd0), .credit_i(c0),
    .credits_o(cr0), .idle_o(idle0), .credit_err_o(err0), .stall_cnt_o(stall0)
  );

  credit_stream_tx #(.T(logic [7:0]), .NumCredits(1)) u1 (
    .clk_i(clk), .rst_i(rst), .src_valid_i(v1), .src_ready_o(rdy1),
    .src_data_i(d1), .tx_valid_o(tx1), .tx_data_o(txd1), .credit_i(c1),
    .credits_o(cr1), .idle_o(idle1), .credit_err_o(err1), .stall_cnt_o(stall1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model state for the randomized run
  logic [7:0] q[$];
  int outstanding = 0;
  int max_out = 0;
  int ord_err = 0;
  int cred_err = 0;
  int pulses = 0;
  logic       acc;
  logic [7:0] accd;
  logic [7:0] expd;

  task automatic model_update();
    if (acc) q.push_back(accd);
    if (c0) outstanding--;
    if (tx0) begin
      pulses++;
      if (q.size() == 0) ord_err++;
      else begin
        expd = q.pop_front();
        if (txd0 !== expd) ord_err++;
      end
      outstanding++;
      if (outstanding > max_out) max_out = outstanding;
    end
    if (int'(cr0) != 4 - outstanding) cred_err++;
  endtask

  function automatic int exp_credits_t3(input int c);
    if (c <= 1) return 4;
    if (c == 2) return 3;
    if (c <= 11) return 2;
    if (c == 12) return 3;
    return 4;
  endfunction

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_credits", 32'(cr0), 32'd4);
    chk("rst_txvalid", 32'(tx0), 32'd0);
    chk("rst_txdata", 32'(txd0), 32'd0);
    chk("rst_err", 32'(err0), 32'd0);
    chk("rst_idle", 32'(idle0), 32'd1);
    chk("rst_ready", 32'(rdy0), 32'd1);
    chk("rst_stall", stall0, 32'd0);
    rst = 1'b0;
    tick();

    // Single flit: accepted cycle 0, on the link in cycle 2
    v0 = 1'b1; d0 = 8'hA5;
    tick();
    v0 = 1'b0; d0 = 8'h00;
    chk("t1_c1_tx", 32'(tx0), 32'd0);
    chk("t1_c1_idle", 32'(idle0), 32'd0);
    tick();
    chk("t1_c2_tx", 32'(tx0), 32'd1);
    chk("t1_c2_data", 32'(txd0), 32'hA5);
    chk("t1_c2_credits", 32'(cr0), 32'd3);
    tick();
    chk("t1_c3_tx", 32'(tx0), 32'd0);
    chk("t1_c3_hold", 32'(txd0), 32'hA5);
    c0 = 1'b1;
    tick();
    c0 = 1'b0;
    chk("t1_credits_back", 32'(cr0), 32'd4);
    chk("t1_idle", 32'(idle0), 32'd1);

    // Credit exhaustion: 6 back-to-back flits, no credit return
    for (int i = 0; i < 6; i++) begin
      v0 = 1'b1; d0 = 8'(16 + i);
      chk("t2_ready", 32'(rdy0), 32'd1);
      tick();
      if (i >= 1 && i <= 4) begin
        chk("t2_tx", 32'(tx0), 32'd1);
        chk("t2_data", 32'(txd0), 32'(16 + i - 1));
      end else begin
        chk("t2_notx", 32'(tx0), 32'd0);
      end
    end
    v0 = 1'b0;
    chk("t2_credits0", 32'(cr0), 32'd0);
    chk("t2_full", 32'(rdy0), 32'd0);
    chk("t2_stall_c6", stall0, Stats ? 32'd1 : 32'd0);
    tick(); tick();
    chk("t2_stall_c8", stall0, Stats ? 32'd3 : 32'd0);
    c0 = 1'b1;
    tick();
    c0 = 1'b0;
    chk("t2_c9_credits", 32'(cr0), 32'd1);
    chk("t2_c9_tx", 32'(tx0), 32'd0);
    tick();
    chk("t2_c10_tx", 32'(tx0), 32'd1);
    chk("t2_c10_data", 32'(txd0), 32'h14);
    chk("t2_c10_credits", 32'(cr0), 32'd0);
    chk("t2_c10_ready", 32'(rdy0), 32'd1);
    tick();
    chk("t2_c11_notx", 32'(tx0), 32'd0);
    for (int j = 0; j < 5; j++) begin
      c0 = 1'b1;
      tick();
      chk("t2_drain_tx", 32'(tx0), (j == 1) ? 32'd1 : 32'd0);
      if (j == 1) chk("t2_drain_data", 32'(txd0), 32'h15);
    end
    c0 = 1'b0;
    chk("t2_end_credits", 32'(cr0), 32'd4);
    chk("t2_end_idle", 32'(idle0), 32'd1);
    chk("t2_end_stall", stall0, Stats ? 32'd6 : 32'd0);

    // Simultaneous send and credit return holds credits at 2, 1 flit/cycle
    for (int i = 0; i < 13; i++) begin
      v0 = (i <= 9);
      d0 = 8'(32 + i);
      c0 = (i >= 3);
      tick();
      chk("t3_ready", 32'(rdy0), 32'd1);
      chk("t3_credits", 32'(cr0), 32'(exp_credits_t3(i + 1)));
      if (i + 1 >= 2 && i + 1 <= 11) begin
        chk("t3_tx", 32'(tx0), 32'd1);
        chk("t3_data", 32'(txd0), 32'(32 + i - 1));
      end else begin
        chk("t3_notx", 32'(tx0), 32'd0);
      end
    end
    v0 = 1'b0; c0 = 1'b0;
    chk("t3_idle", 32'(idle0), 32'd1);

    // Overflow: credit returned with the counter full
    c0 = 1'b1;
    tick();
    c0 = 1'b0;
    chk("t4_credits", 32'(cr0), 32'd4);
    chk("t4_err", 32'(err0), 32'd1);
    tick(); tick();
    chk("t4_err_sticky", 32'(err0), 32'd1);
    chk("t4_credits_hold", 32'(cr0), 32'd4);

    // NumCredits=1: next send waits for the credit plus one cycle
    v1 = 1'b1; d1 = 8'h40;
    tick();
    d1 = 8'h41;
    chk("t6_ready", 32'(rdy1), 32'd1);
    tick();
    v1 = 1'b0;
    chk("t6_c2_tx", 32'(tx1), 32'd1);
    chk("t6_c2_data", 32'(txd1), 32'h40);
    chk("t6_c2_credits", 32'(cr1), 32'd0);
    tick();
    chk("t6_c3_tx", 32'(tx1), 32'd0);
    c1 = 1'b1;
    tick();
    c1 = 1'b0;
    chk("t6_c4_tx", 32'(tx1), 32'd0);
    chk("t6_c4_credits", 32'(cr1), 32'd1);
    tick();
    chk("t6_c5_tx", 32'(tx1), 32'd1);
    chk("t6_c5_data", 32'(txd1), 32'h41);
    tick();
    chk("t6_c6_tx", 32'(tx1), 32'd0);
    c1 = 1'b1;
    tick();
    c1 = 1'b0;
    chk("t6_idle", 32'(idle1), 32'd1);

    // Reset mid-operation with 2 buffered flits and one credit
    for (int i = 0; i < 6; i++) begin
      v0 = 1'b1; d0 = 8'(48 + i);
      c0 = (i == 5);
      tick();
    end
    v0 = 1'b0; c0 = 1'b0;
    chk("t5_pre_credits", 32'(cr0), 32'd1);
    chk("t5_pre_full", 32'(rdy0), 32'd0);
    rst = 1'b1;
    #1;
    chk("t5_credits", 32'(cr0), 32'd4);
    chk("t5_idle", 32'(idle0), 32'd1);
    chk("t5_txvalid", 32'(tx0), 32'd0);
    chk("t5_txdata", 32'(txd0), 32'd0);
    chk("t5_err", 32'(err0), 32'd0);
    chk("t5_ready", 32'(rdy0), 32'd1);
    chk("t5_stall", stall0, 32'd0);
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_no_tx", 32'(tx0), 32'd0);
    end

    // Randomized ordering against a reference queue and receiver model
    acc = 1'b0; accd = '0;
    for (int n = 0; n < 10000; n++) begin
      if (!(v0 && !rdy0)) begin
        v0 = ($urandom_range(0, 2) != 0);
        d0 = 8'($urandom);
      end
      c0 = (outstanding > 0) && ($urandom_range(0, 3) != 0);
      acc = v0 && rdy0;
      accd = d0;
      tick();
      model_update();
    end
    v0 = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (q.size() == 0 && outstanding == 0 && idle0) break;
      c0 = (outstanding > 0);
      acc = 1'b0;
      tick();
      model_update();
    end
    c0 = 1'b0;
    chk("rnd_order", 32'(ord_err), 32'd0);
    chk("rnd_credits", 32'(cred_err), 32'd0);
    chk("rnd_max_outstanding", 32'(max_out <= 4), 32'd1);
    chk("rnd_traffic", 32'(pulses > 1000), 32'd1);
    chk("rnd_queue_empty", 32'(q.size()), 32'd0);
    chk("rnd_idle", 32'(idle0), 32'd1);
    chk("rnd_no_err", 32'(err0), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
